// File: rtl/adder_pkg.sv
// Shared types and helpers for the adder tree front end.
//   collector_state_t : collector FSM encoding
//   popcount          : number of set bits in a mask of up to MAX_INPUT bits
package adder_pkg;

  localparam int MAX_INPUT = 64;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } collector_state_t;

  function automatic int unsigned popcount(input logic [MAX_INPUT-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_INPUT; i++) begin
      n += {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/adder_frame_collector.sv
// Assembles a scalar (data, idx) sample stream into a NUM_INPUT-wide frame
// with a participation mask, for the multi-input adder tree.
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_ena                 : clock enable, low freezes state and both handshakes
//   i_valid/o_ready       : sample handshake (i_data, i_idx, i_last)
//   o_valid/i_ready       : frame handshake (o_data, o_input_enable, o_count)
//   o_dup, o_range_err    : one-cycle pulses after an overwrite / bad index
//
// state   | meaning
// --------+--------------------------------------------------------------
// COLLECT | filling slots; o_valid low
// HOLD    | frame complete; presented until transfer (may refill same edge)
module adder_frame_collector
  import adder_pkg::*;
#(
  parameter  int NUM_INPUT = 8,
  parameter  int WIDTH_IN  = 16,
  localparam int IDX_W     = $clog2(NUM_INPUT),
  localparam int CNT_W     = $clog2(NUM_INPUT + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ena,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [WIDTH_IN-1:0] i_data,
  input  logic [IDX_W-1:0]    i_idx,
  input  logic                i_last,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [WIDTH_IN-1:0] o_data [NUM_INPUT],
  output logic [NUM_INPUT-1:0] o_input_enable,
  output logic [CNT_W-1:0]    o_count,
  output logic                o_dup,
  output logic                o_range_err
);

  collector_state_t state;

  logic                 accept;
  logic                 xfer;
  logic                 in_range;
  logic [NUM_INPUT-1:0] hit;
  logic [NUM_INPUT-1:0] base_mask;
  logic [NUM_INPUT-1:0] new_mask;
  logic                 dup_hit;
  logic                 close;

  assign o_ready = i_ena & ((state == COLLECT) | ((state == HOLD) & i_ready));
  assign o_valid = i_ena & (state == HOLD);
  assign accept  = i_valid & o_ready;
  assign xfer    = o_valid & i_ready;

  assign in_range = int'(i_idx) < NUM_INPUT;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_INPUT; i++) begin
      if (in_range && (int'(i_idx) == i)) hit[i] = 1'b1;
    end
  end

  // An accept while in HOLD always coincides with a transfer, so the new
  // frame starts from an empty mask.
  assign base_mask = (state == COLLECT) ? o_input_enable : '0;
  assign new_mask  = base_mask | hit;
  assign dup_hit   = |(base_mask & hit);
  assign close     = i_last | (&new_mask);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= COLLECT;
      o_input_enable <= '0;
      o_count        <= '0;
      o_dup          <= 1'b0;
      o_range_err    <= 1'b0;
      for (int i = 0; i < NUM_INPUT; i++) o_data[i] <= '0;
    end else if (!i_ena) begin
      o_dup       <= 1'b0;
      o_range_err <= 1'b0;
    end else begin
      o_dup       <= 1'b0;
      o_range_err <= 1'b0;
      if (accept) begin
        for (int i = 0; i < NUM_INPUT; i++) begin
          if (hit[i]) o_data[i] <= i_data;
        end
        o_input_enable <= new_mask;
        o_count        <= CNT_W'(popcount(MAX_INPUT'(new_mask)));
        o_dup          <= dup_hit;
        o_range_err    <= ~in_range;
        state          <= close ? HOLD : COLLECT;
      end else if (xfer) begin
        // Slot data left in place; masked-off slots are don't-care.
        o_input_enable <= '0;
        o_count        <= '0;
        state          <= COLLECT;
      end
    end
  end

endmodule

// File: tb/tb_adder_frame_collector.sv
module tb_adder_frame_collector;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_ena;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_data;
  logic [2:0]  i_idx;
  logic        i_last;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_data [8];
  logic [7:0]  o_input_enable;
  logic [3:0]  o_count;
  logic        o_dup;
  logic        o_range_err;

  // Second instance with 6 slots so that an out-of-range index is reachable.
  logic        r_valid;
  logic        r_ready_o;
  logic [15:0] r_data_i;
  logic [2:0]  r_idx;
  logic        r_last;
  logic        r_valid_o;
  logic        r_ready;
  logic [15:0] r_data [6];
  logic [5:0]  r_mask;
  logic [2:0]  r_count;
  logic        r_dup;
  logic        r_err;

  int checks   = 0;
  int failures = 0;

  adder_frame_collector #(.NUM_INPUT(8), .WIDTH_IN(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ena(i_ena),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_idx(i_idx),
    .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_input_enable(o_input_enable), .o_count(o_count), .o_dup(o_dup),
    .o_range_err(o_range_err)
  );

  adder_frame_collector #(.NUM_INPUT(6), .WIDTH_IN(16)) dut6 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ena(1'b1),
    .i_valid(r_valid), .o_ready(r_ready_o), .i_data(r_data_i), .i_idx(r_idx),
    .i_last(r_last), .o_valid(r_valid_o), .i_ready(r_ready), .o_data(r_data),
    .o_input_enable(r_mask), .o_count(r_count), .o_dup(r_dup),
    .o_range_err(r_err)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        valid;
    logic [2:0]  idx;
    logic [15:0] data;
    logic        last;
    logic        ready;
    logic        exp_ready;
    logic        exp_valid;
    logic [7:0]  exp_mask;
    logic [3:0]  exp_count;
    logic        exp_dup;
    logic        chk_slot;
    logic [15:0] exp_slot;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(logic v, logic [2:0] idx, logic [15:0] d, logic l,
                              logic rdy, logic er, logic ev, logic [7:0] em,
                              logic [3:0] ec, logic ed, logic cs, logic [15:0] es);
    vec_t t;
    t.valid = v; t.idx = idx; t.data = d; t.last = l; t.ready = rdy;
    t.exp_ready = er; t.exp_valid = ev; t.exp_mask = em; t.exp_count = ec;
    t.exp_dup = ed; t.chk_slot = cs; t.exp_slot = es;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int n);
    i_valid = v.valid; i_idx = v.idx; i_data = v.data;
    i_last = v.last; i_ready = v.ready;
    @(negedge i_clk);
    chk($sformatf("v%0d_o_ready", n), 32'(o_ready), 32'(v.exp_ready));
    tick();
    chk($sformatf("v%0d_o_valid", n), 32'(o_valid), 32'(v.exp_valid));
    chk($sformatf("v%0d_mask", n), 32'(o_input_enable), 32'(v.exp_mask));
    chk($sformatf("v%0d_count", n), 32'(o_count), 32'(v.exp_count));
    chk($sformatf("v%0d_dup", n), 32'(o_dup), 32'(v.exp_dup));
    if (v.chk_slot)
      chk($sformatf("v%0d_slot%0d", n, v.idx), 32'(o_data[v.idx]), 32'(v.exp_slot));
  endtask

  initial begin
    //               v  idx  data    l  rdy er ev mask   cnt dup cs slot
    vecs[0]  = mk(1, 0, 16'h0011, 0, 1, 1, 0, 8'h01, 1, 0, 1, 16'h0011);
    vecs[1]  = mk(1, 3, 16'h0022, 0, 1, 1, 0, 8'h09, 2, 0, 1, 16'h0022);
    vecs[2]  = mk(1, 5, 16'h0033, 1, 1, 1, 1, 8'h29, 3, 0, 1, 16'h0033);
    vecs[3]  = mk(0, 0, 16'h0000, 0, 1, 1, 0, 8'h00, 0, 0, 0, 16'h0000);
    for (int i = 0; i < 7; i++)
      vecs[4+i] = mk(1, 3'(i), 16'(16'h0100 + i), 0, 0, 1, 0,
                     8'((1 << (i + 1)) - 1), 4'(i + 1), 0, 1, 16'(16'h0100 + i));
    vecs[11] = mk(1, 7, 16'h0107, 0, 0, 1, 1, 8'hFF, 8, 0, 1, 16'h0107);
    vecs[12] = mk(1, 0, 16'h0999, 0, 0, 0, 1, 8'hFF, 8, 0, 1, 16'h0100);
    for (int i = 13; i < 17; i++)
      vecs[i] = mk(0, 0, 16'h0000, 0, 0, 0, 1, 8'hFF, 8, 0, 1, 16'h0100);
    vecs[17] = mk(1, 2, 16'hBEEF, 0, 1, 1, 0, 8'h04, 1, 0, 1, 16'hBEEF);
    vecs[18] = mk(1, 6, 16'h0066, 1, 1, 1, 1, 8'h44, 2, 0, 1, 16'h0066);
    vecs[19] = mk(0, 0, 16'h0000, 0, 1, 1, 0, 8'h00, 0, 0, 0, 16'h0000);
    vecs[20] = mk(1, 1, 16'hAAAA, 0, 1, 1, 0, 8'h02, 1, 0, 1, 16'hAAAA);
    vecs[21] = mk(1, 1, 16'h5555, 1, 1, 1, 1, 8'h02, 1, 1, 1, 16'h5555);
    vecs[22] = mk(0, 0, 16'h0000, 0, 1, 1, 0, 8'h00, 0, 0, 0, 16'h0000);

    i_rst_n = 1'b0; i_ena = 1'b1; i_valid = 1'b0; i_data = '0; i_idx = '0;
    i_last = 1'b0; i_ready = 1'b0;
    r_valid = 1'b0; r_data_i = '0; r_idx = '0; r_last = 1'b0; r_ready = 1'b0;

    tick();
    chk("rst_mask", 32'(o_input_enable), 32'h0);
    chk("rst_count", 32'(o_count), 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_dup", 32'(o_dup), 32'h0);
    chk("rst_range_err", 32'(o_range_err), 32'h0);
    chk("rst_slot7", 32'(o_data[7]), 32'h0);
    i_rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(o_ready), 32'h1);

    for (int n = 0; n < NV; n++) apply(vecs[n], n);
    i_valid = 1'b0; i_last = 1'b0;

    // Reset mid-frame with two slots written.
    i_valid = 1'b1; i_idx = 3'd0; i_data = 16'h1111; tick();
    i_idx = 3'd1; i_data = 16'h2222; tick();
    chk("mid_mask_before_rst", 32'(o_input_enable), 32'h03);
    i_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_mask", 32'(o_input_enable), 32'h0);
    chk("mid_rst_count", 32'(o_count), 32'h0);
    chk("mid_rst_slot0", 32'(o_data[0]), 32'h0);
    tick();
    i_rst_n = 1'b1;
    #1;
    chk("mid_rst_collect_ready", 32'(o_ready), 32'h1);
    chk("mid_rst_valid", 32'(o_valid), 32'h0);

    // Clock enable low while holding a frame.
    i_valid = 1'b1; i_idx = 3'd4; i_data = 16'h4444; i_last = 1'b1; i_ready = 1'b0;
    tick();
    chk("ena_hold_valid", 32'(o_valid), 32'h1);
    i_ena = 1'b0; i_ready = 1'b1; i_idx = 3'd0; i_data = 16'h1234; i_last = 1'b0;
    #1;
    chk("ena0_valid", 32'(o_valid), 32'h0);
    chk("ena0_ready", 32'(o_ready), 32'h0);
    repeat (3) tick();
    chk("ena0_mask", 32'(o_input_enable), 32'h10);
    chk("ena0_count", 32'(o_count), 32'h1);
    chk("ena0_slot0", 32'(o_data[0]), 32'h0);
    chk("ena0_slot4", 32'(o_data[4]), 32'h4444);
    i_ena = 1'b1; i_valid = 1'b0;
    #1;
    chk("ena1_valid", 32'(o_valid), 32'h1);
    tick();
    chk("ena1_xfer_valid", 32'(o_valid), 32'h0);
    chk("ena1_xfer_mask", 32'(o_input_enable), 32'h0);

    // Out-of-range closing sample on an empty frame (6-slot instance).
    r_valid = 1'b1; r_idx = 3'd7; r_data_i = 16'hDEAD; r_last = 1'b1; r_ready = 1'b1;
    tick();
    chk("rng_err_pulse", 32'(r_err), 32'h1);
    chk("rng_valid", 32'(r_valid_o), 32'h1);
    chk("rng_mask", 32'(r_mask), 32'h0);
    chk("rng_count", 32'(r_count), 32'h0);
    chk("rng_dup", 32'(r_dup), 32'h0);
    r_valid = 1'b0; r_last = 1'b0;
    tick();
    chk("rng_err_clear", 32'(r_err), 32'h0);
    chk("rng_valid_clear", 32'(r_valid_o), 32'h0);
    chk("rng_ready", 32'(r_ready_o), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
